// File: rtl/instr_decoder_pipe.sv
// rtl/instr_decoder_pipe.sv - pipelined variable-length instruction decoder
//
// Takes instruction words from fetch over in_valid/in_ready. A base word with its
// MSB set (when LONG_EN) waits in a holding register for one extension word. Each
// completed instruction is decoded into a registered bundle that is handed to
// execute over out_valid/out_ready.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              drops the partial instruction and the pending bundle
//   in_word/in_valid/in_ready                  instruction word stream from fetch
//   out_valid/out_ready                        decoded bundle handshake
//   out_opcode/out_ra/out_rb/out_imm/out_long/out_illegal  decoded bundle fields
//   instr_count        number of bundles consumed, wraps
module instr_decoder_pipe #(
    parameter int INSTR_WIDTH = 16,
    parameter int NUM_REGS    = 16,
    parameter int NUM_OPCODES = 64,
    parameter int LONG_EN     = 1,
    parameter int CNT_WIDTH   = 8,
    localparam int REG_IDX_W  = $clog2(NUM_REGS),
    localparam int OPC_W      = INSTR_WIDTH - 2*REG_IDX_W - LONG_EN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] in_word,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPC_W-1:0]       out_opcode,
    output logic [REG_IDX_W-1:0]   out_ra,
    output logic [REG_IDX_W-1:0]   out_rb,
    output logic [INSTR_WIDTH-1:0] out_imm,
    output logic                   out_long,
    output logic                   out_illegal,
    output logic [CNT_WIDTH-1:0]   instr_count
);
    // Bits of a base word that carry opcode and register fields; the long flag
    // (when present) is not needed once the word sits in the holding register.
    localparam int BODY_W = INSTR_WIDTH - LONG_EN;

    typedef enum logic {S_BASE, S_EXT} state_t;

    state_t                 state_q, state_d;
    logic [BODY_W-1:0]      hold_q, hold_d;
    logic                   valid_q, valid_d;
    logic [OPC_W-1:0]       opc_q, opc_d;
    logic [REG_IDX_W-1:0]   ra_q, ra_d;
    logic [REG_IDX_W-1:0]   rb_q, rb_d;
    logic [INSTR_WIDTH-1:0] imm_q, imm_d;
    logic                   long_q, long_d;
    logic                   ill_q, ill_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic              accept;
    logic              is_long;
    logic [BODY_W-1:0] src;
    logic [OPC_W-1:0]  src_opc;

    // Ready depends only on flush and the output stage, never on in_valid.
    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_long  = (LONG_EN != 0) && in_word[INSTR_WIDTH-1];

    // Fields come from the held base word when completing a long instruction.
    assign src     = (state_q == S_EXT) ? hold_q : in_word[BODY_W-1:0];
    assign src_opc = src[BODY_W-1:2*REG_IDX_W];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        imm_d   = imm_q;
        long_d  = long_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;

        if (valid_q && out_ready && !flush) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        if (flush) begin
            state_d = S_BASE;
            valid_d = 1'b0;
        end else begin
            if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
            if (accept) begin
                if (state_q == S_BASE && is_long) begin
                    hold_d  = in_word[BODY_W-1:0];
                    state_d = S_EXT;
                end else begin
                    valid_d = 1'b1;
                    opc_d   = src_opc;
                    ra_d    = src[2*REG_IDX_W-1:REG_IDX_W];
                    rb_d    = src[REG_IDX_W-1:0];
                    imm_d   = (state_q == S_EXT) ? in_word : '0;
                    long_d  = (state_q == S_EXT);
                    ill_d   = 32'(src_opc) >= 32'(NUM_OPCODES);
                    state_d = S_BASE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BASE;
            hold_q  <= '0;
            valid_q <= 1'b0;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            imm_q   <= '0;
            long_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            imm_q   <= imm_d;
            long_q  <= long_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_opcode  = opc_q;
    assign out_ra      = ra_q;
    assign out_rb      = rb_q;
    assign out_imm     = imm_q;
    assign out_long    = long_q;
    assign out_illegal = ill_q;
    assign instr_count = cnt_q;

endmodule

// File: doc/instr_decoder_pipe.md
Name: instr_decoder_pipe

Overview:
Parametrised, pipelined successor to the CPU's instruction decoder.
- Accepts a stream of instruction words over a valid/ready handshake.
- Assembles variable-length instructions: one base word, optionally followed by one extension word.
- Produces a registered, decoded instruction bundle over a second valid/ready handshake.
- Sits between the fetch unit and the execute stage. Supports flush on branches, illegal-opcode flagging and a decoded-instruction counter.

Parameters:
INSTR_WIDTH, 16, width of one instruction word and of the immediate.
NUM_REGS, 16, register-file size; REG_IDX_W = $clog2(NUM_REGS).
NUM_OPCODES, 64, opcodes 0..NUM_OPCODES-1 are legal. Must be <= 2**OPC_W.
LONG_EN, 1, 1 = bit [INSTR_WIDTH-1] marks a two-word instruction; 0 = every instruction is one word and that bit becomes the opcode MSB.
CNT_WIDTH, 8, width of the decoded-instruction counter.

Ports:
clk  in  1  clock, all state rising-edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous; discards the partial instruction and the output bundle.
in_word  in  INSTR_WIDTH  instruction word from fetch.
in_valid  in  1  in_word valid.
in_ready  out  1  decoder accepts in_word this cycle.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  downstream consumes the bundle.
out_opcode  out  OPC_W  opcode. OPC_W = INSTR_WIDTH - 2*REG_IDX_W - LONG_EN.
out_ra  out  REG_IDX_W  register A index, bits [2*REG_IDX_W-1:REG_IDX_W].
out_rb  out  REG_IDX_W  register B index, bits [REG_IDX_W-1:0].
out_imm  out  INSTR_WIDTH  extension word; 0 for short instructions.
out_long  out  1  bundle came from a two-word instruction.
out_illegal  out  1  opcode >= NUM_OPCODES.
instr_count  out  CNT_WIDTH  number of bundles consumed (out_valid & out_ready).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = S_BASE.
  - out_valid = 0.
  - out_opcode / ra / rb / imm / long / illegal = 0.
  - instr_count = 0.
  - Base-word holding register = 0.
- Word accept: a word is accepted when in_valid & in_ready.
  - in_ready = !flush & (!out_valid | out_ready), in both states.
  - in_ready must not depend combinationally on in_valid.
- State S_BASE, word accepted:
  - If LONG_EN and word[MSB] = 1: latch the word into the holding register and go to S_EXT. Output is unchanged.
  - Otherwise: load the output registers from the word, with imm = 0 and long = 0. Set out_valid = 1 next cycle. Stay in S_BASE.
- State S_EXT, word accepted:
  - Fields come from the holding register; imm = the accepted word; long = 1.
  - out_valid = 1 next cycle. Go to S_BASE.
- Latency:
  - Short instruction accepted at cycle N gives out_valid at N+1.
  - Long instruction whose extension is accepted at cycle M gives out_valid at M+1.
  - Full throughput is one word per cycle when out_ready is held high.
- Output hold: while out_valid & !out_ready, all out_* fields stay stable and no word is accepted.
- Simultaneous consume and accept: out_valid & out_ready together with a completing accept reloads the output, and out_valid stays 1 (back-to-back). With no completing accept, out_valid falls to 0.
- out_illegal: registered with the bundle, computed as opcode >= NUM_OPCODES. The bundle is still emitted; the execute stage raises the trap.
- flush (highest priority):
  - Next cycle: state = S_BASE, out_valid = 0.
  - The holding register and out_* data may retain stale values.
  - in_ready = 0 during the flush cycle, so no word is consumed.
  - instr_count is not incremented for a bundle flushed in the same cycle as out_ready.
- instr_count: increments on out_valid & out_ready & !flush and wraps modulo 2**CNT_WIDTH. Flush does not clear it.
- Reset mid-instruction (in S_EXT): the holding register is discarded and the next word is decoded as a base word.

Test Plan:
1. Reset, then feed short word 0x0A35 with out_ready = 1 -> one cycle later out_valid = 1, opcode = 0x0A, ra = 3, rb = 5, imm = 0, long = 0, illegal = 0; instr_count = 1 after the consume.
2. Feed long pair 0x8C12, 0xBEEF back-to-back -> out_valid = 1 only after the second word; opcode = 0x0C, ra = 1, rb = 2, imm = 0xBEEF, long = 1.
3. Short word 0x7F00 with NUM_OPCODES = 64 -> opcode = 0x7F, out_illegal = 1, bundle emitted normally.
4. Backpressure: hold out_ready = 0 for 5 cycles while in_valid = 1 -> in_ready = 0 and outputs stable throughout; release -> 3 queued short words emerge on 3 consecutive cycles.
5. Send 0x8C12, then assert flush before the extension word -> state returns to S_BASE; the next word 0x0A35 decodes as short (opcode 0x0A); no long bundle appears.
6. Assert rst_n low asynchronously mid-stream, then LONG_EN = 0 build with word 0x8A35 -> all outputs are 0 immediately on reset; after reset the word decodes as one word with opcode = 0x8A; counter wrap from 0xFF to 0x00 is checked with CNT_WIDTH = 8.
